// File: rtl/mips_pkg.sv
// Shared types and constants for the EX-stage HI/LO divide unit.
package mips_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Pipeline-side bundle of the divide unit: start/operands, stall, MTHI/MTLO and HI/LO.
interface div_unit_if
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);

    logic             start;
    logic             isSigned;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             hold;
    logic             cancel;
    logic             hiWrite;
    logic             loWrite;
    logic [WIDTH-1:0] hiLoData;
    logic             EX_requireStall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output start, isSigned, dividend, divisor, hold, cancel,
        output hiWrite, loWrite, hiLoData,
        input  EX_requireStall, hi, lo, busy
    );

    modport slave (
        input  start, isSigned, dividend, divisor, hold, cancel,
        input  hiWrite, loWrite, hiLoData,
        output EX_requireStall, hi, lo, busy
    );

endinterface

// File: rtl/div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and trial-subtract.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The remainder stays below the divisor, so a successful subtraction always fits WIDTH bits.
    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {1'b0, divisor_i};
    assign q_o     = ~trial[WIDTH];
    assign rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit owning HI/LO; stalls the pipeline while a divide is in flight.
// Optional build macro DIV_EARLY_ZERO_EN: a zero divisor skips the CALC sequence.
module div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
`ifdef DIV_EARLY_ZERO_EN
    localparam bit EARLY_ZERO = 1'b1;
`else
    localparam bit EARLY_ZERO = 1'b0;
`endif

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend magnitude shifts out as quotient shifts in
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic             neg_q, neg_d;
    logic             rsgn_q, rsgn_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             go;

    div_iter #(.WIDTH(WIDTH)) u_iter (
        .rem_i    (rem_q),
        .bit_i    (quo_q[WIDTH-1]),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

    assign dvd_neg = bus.isSigned & bus.dividend[WIDTH-1];
    assign dvs_neg = bus.isSigned & bus.divisor[WIDTH-1];
    assign go      = bus.start & ~bus.cancel;

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        raw_d   = raw_q;
        neg_d   = neg_q;
        rsgn_d  = rsgn_q;
        zero_d  = zero_q;
        hi_d    = bus.hiWrite ? bus.hiLoData : hi_q;
        lo_d    = bus.loWrite ? bus.hiLoData : lo_q;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    quo_d   = dvd_neg ? -bus.dividend : bus.dividend;
                    dvs_d   = dvs_neg ? -bus.divisor : bus.divisor;
                    raw_d   = bus.dividend;
                    neg_d   = dvd_neg ^ dvs_neg;
                    rsgn_d  = dvd_neg;
                    zero_d  = (bus.divisor == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (EARLY_ZERO && bus.divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    // The divide is younger than any MTHI/MTLO in WB, so its result takes priority.
                    if (zero_q) begin
                        lo_d = '1;
                        hi_d = raw_q;
                    end else begin
                        lo_d = neg_q ? -quo_q : quo_q;
                        hi_d = rsgn_q ? -rem_q : rem_q;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            raw_q   <= '0;
            neg_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            raw_q   <= raw_d;
            neg_q   <= neg_d;
            rsgn_q  <= rsgn_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.EX_requireStall = (state_q == IDLE && go) || state_q == CALC || state_q == FIX;
    assign bus.busy            = (state_q == CALC) || (state_q == FIX);
    assign bus.hi              = hi_q;
    assign bus.lo              = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, hand-written corner sequences, random vs. arithmetic model.
module tb_div_unit;

`ifdef DIV_EARLY_ZERO_EN
    localparam int ZERO_STALL = 2;
`else
    localparam int ZERO_STALL = 34;
`endif
    localparam int FULL_STALL = 34;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    div_unit_if #(.WIDTH(32)) ifc ();

    div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: MIPS semantics from plain integer arithmetic (truncating division, remainder sign of dividend).
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Called #1 after a rising edge with the unit in IDLE; returns #1 after the edge leaving DONE.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        int exp_n;
        exp_n        = (b == 32'd0) ? ZERO_STALL : FULL_STALL;
        ifc.start    = 1'b1;
        ifc.isSigned = sgn;
        ifc.dividend = a;
        ifc.divisor  = b;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!ifc.EX_requireStall) break;
            n++;
            tick();
            ifc.start = 1'b0;
        end
        check({name, " stall cycles"}, 32'(n), 32'(exp_n));
        check({name, " lo"}, ifc.lo, exp_lo);
        check({name, " hi"}, ifc.hi, exp_hi);
        ifc.start = 1'b0;
        tick();
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] m_lo, m_hi, ra, rb;
        logic        rs;
        int          n;

        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{"divu 100/7",        1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
        vecs[1] = '{"div -7/2",          1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[2] = '{"div ovf",           1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        vecs[3] = '{"divu by zero",      1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678};
        vecs[4] = '{"div by zero neg",   1'b1, 32'h8765_4321, 32'd0,         32'hFFFF_FFFF, 32'h8765_4321};
        vecs[5] = '{"divu max/1",        1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
        vecs[6] = '{"div 7/-2",          1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vecs[7] = '{"divu 5/9",          1'b0, 32'd5,         32'd9,         32'd0,         32'd5};

        rst          = 1'b1;
        ifc.start    = 1'b0;
        ifc.isSigned = 1'b0;
        ifc.dividend = '0;
        ifc.divisor  = '0;
        ifc.hold     = 1'b0;
        ifc.cancel   = 1'b0;
        ifc.hiWrite  = 1'b0;
        ifc.loWrite  = 1'b0;
        ifc.hiLoData = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset stall", 32'(ifc.EX_requireStall), 32'd0);
        check("reset busy",  32'(ifc.busy), 32'd0);
        check("reset hi",    ifc.hi, 32'd0);
        check("reset lo",    ifc.lo, 32'd0);
        tick();

        for (int i = 0; i < 8; i++)
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp_lo, vecs[i].exp_hi);

        // Cancel in cycle 10: HI/LO preloaded via MTHI/MTLO must survive.
        ifc.hiWrite = 1'b1; ifc.loWrite = 1'b1; ifc.hiLoData = 32'hAAAA;
        tick();
        ifc.hiWrite = 1'b0; ifc.loWrite = 1'b0;
        ifc.start = 1'b1; ifc.isSigned = 1'b0; ifc.dividend = 32'd100; ifc.divisor = 32'd7;
        tick();
        ifc.start = 1'b0;
        repeat (9) tick();
        ifc.cancel = 1'b1;
        @(negedge clk);
        check("cancel c10 stall", 32'(ifc.EX_requireStall), 32'd1);
        tick();
        ifc.cancel = 1'b0;
        @(negedge clk);
        check("cancel c11 stall", 32'(ifc.EX_requireStall), 32'd0);
        check("cancel c11 busy",  32'(ifc.busy), 32'd0);
        repeat (40) tick();
        check("cancel hi kept", ifc.hi, 32'hAAAA);
        check("cancel lo kept", ifc.lo, 32'hAAAA);

        // Completion with hold=1 and start held high: DONE must neither restart nor stall.
        ifc.hold = 1'b1;
        ifc.start = 1'b1; ifc.isSigned = 1'b0; ifc.dividend = 32'd100; ifc.divisor = 32'd7;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!ifc.EX_requireStall) break;
            n++;
            tick();
        end
        check("hold stall cycles", 32'(n), 32'd34);
        check("hold lo", ifc.lo, 32'd14);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("hold done%0d stall", k), 32'(ifc.EX_requireStall), 32'd0);
            check($sformatf("hold done%0d busy", k),  32'(ifc.busy), 32'd0);
            tick();
        end
        ifc.start = 1'b0;
        ifc.hold  = 1'b0;
        tick();
        @(negedge clk);
        check("hold released busy", 32'(ifc.busy), 32'd0);
        tick();

        // MTHI during CALC is visible next cycle, then replaced by the remainder.
        ifc.start = 1'b1; ifc.isSigned = 1'b0; ifc.dividend = 32'd100; ifc.divisor = 32'd7;
        tick();
        ifc.start = 1'b0;
        repeat (4) tick();
        ifc.hiWrite = 1'b1; ifc.hiLoData = 32'h55;
        tick();
        ifc.hiWrite = 1'b0;
        @(negedge clk);
        check("mthi calc hi", ifc.hi, 32'h55);
        n = 0;
        while (n < 200 && ifc.EX_requireStall) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("mthi final hi", ifc.hi, 32'd2);
        check("mthi final lo", ifc.lo, 32'd14);
        tick();

        // MTLO in the FIX cycle (cycle 33) loses to the quotient.
        ifc.start = 1'b1; ifc.isSigned = 1'b0; ifc.dividend = 32'd100; ifc.divisor = 32'd7;
        tick();
        ifc.start = 1'b0;
        repeat (32) tick();
        ifc.loWrite = 1'b1; ifc.hiLoData = 32'h1234;
        @(negedge clk);
        check("mtlo fix stall", 32'(ifc.EX_requireStall), 32'd1);
        tick();
        ifc.loWrite = 1'b0;
        @(negedge clk);
        check("mtlo fix done stall", 32'(ifc.EX_requireStall), 32'd0);
        check("mtlo fix lo", ifc.lo, 32'd14);
        tick();

        repeat (24) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 255));
                3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            ref_div(rs, ra, rb, m_lo, m_hi);
            run_div($sformatf("rand %0d %h/%h", rs, ra, rb), rs, ra, rb, m_lo, m_hi);
        end

        // Asynchronous reset in the middle of a divide.
        ifc.start = 1'b1; ifc.isSigned = 1'b1; ifc.dividend = 32'd1000; ifc.divisor = 32'd3;
        tick();
        ifc.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("midreset stall", 32'(ifc.EX_requireStall), 32'd0);
        check("midreset busy",  32'(ifc.busy), 32'd0);
        check("midreset hi",    ifc.hi, 32'd0);
        check("midreset lo",    ifc.lo, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative MIPS DIV/DIVU unit living in the EX stage, owning the HI/LO register pair. It accepts one divide per start and computes one quotient bit per cycle. It drives `EX_requireStall` into `PipelineControl`, so the divide instruction and everything younger hold in place until HI/LO are written. It also serves MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
- `WIDTH`, 32, operand/result width; the counter is `$clog2(WIDTH)` bits.

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: EX holds a valid DIV/DIVU.
- `isSigned` in 1: 1 = DIV, 0 = DIVU; sampled with `start`.
- `dividend` in WIDTH: rs value; sampled with `start`.
- `divisor` in WIDTH: rt value; sampled with `start`.
- `hold` in 1: EX is held by a downstream stall (`EX_MEM_stall`).
- `cancel` in 1: the EX instruction is being flushed (`ID_EX_flush`/exception).
- `hiWrite` in 1: MTHI write enable, from WB.
- `loWrite` in 1: MTLO write enable, from WB.
- `hiLoData` in WIDTH: MTHI/MTLO data.
- `EX_requireStall` out 1: to `PipelineControl`.
- `hi` out WIDTH: HI register, read by MFHI.
- `lo` out WIDTH: LO register, read by MFLO.
- `busy` out 1: state is not IDLE or DONE.

## Operation
- **States:**
  - IDLE, CALC, FIX, DONE.
  - Reset: state=IDLE, counter=0, `hi`=`lo`=0, `EX_requireStall`=0, `busy`=0.
- **IDLE:**
  - If `start` and not `cancel`, latch magnitudes |dividend| and |divisor| (raw values when unsigned) and the sign flags.
  - Clear the partial remainder, then go to CALC.
- **CALC:**
  - One restoring step per cycle: shift in the next dividend bit and trial-subtract.
  - Quotient bit = not borrow.
  - After WIDTH steps go to FIX.
- **FIX:**
  - Apply signs. Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Write LO=quotient, HI=remainder, then go to DONE.
- **Divisor zero:** FIX forces LO=all ones and HI=raw dividend, regardless of `isSigned`.
- **Signed overflow:** 0x80000000 / -1 yields LO=0x80000000, HI=0 naturally; no special case.
- **DONE:**
  - `start` is ignored, so the same instruction cannot retrigger.
  - Stay in DONE while `hold`=1; otherwise return to IDLE.
- **`EX_requireStall`:**
  - Combinational: (IDLE & `start` & !`cancel`) | CALC | FIX.
  - Low in DONE.
- **`cancel`:**
  - In CALC or FIX: go to IDLE next edge with no HI/LO write.
  - In IDLE: suppresses start.
- **MTHI/MTLO:**
  - Writes apply in any state.
  - If a write coincides with the FIX write, the divide result wins, because the divide is younger in program order.
- `hi`/`lo` are direct register outputs; there is no forwarding inside the block.

## Timing
- Start accepted in cycle 0; CALC occupies cycles 1..WIDTH; FIX is cycle WIDTH+1.
- HI/LO are updated at the end of cycle WIDTH+1 and are visible from cycle WIDTH+2, when DONE is entered.
- `EX_requireStall` is high for exactly WIDTH+2 cycles (34 at WIDTH=32).
- A back-to-back divide can start at the earliest in the cycle after DONE exits to IDLE.
- Reset asserted mid-operation returns to IDLE immediately, with HI/LO=0 and the stall released.

## Configuration
- **`DIV_EARLY_ZERO_EN`**
  - Defined: a zero divisor seen in IDLE goes straight to FIX.
    - Stall lasts 2 cycles.
    - HI/LO are visible in cycle 2.
  - Undefined: a zero divisor runs the full CALC sequence, with a 34-cycle stall.
  - In both cases the result values are identical (LO=all ones, HI=dividend).

## Structure
- **`mips_pkg`:**
  - Holds the `div_state_t` enum (IDLE/CALC/FIX/DONE) and the `DATA_WIDTH` constant.
  - `WIDTH` defaults to `DATA_WIDTH`.
- **Sub-module `div_iter`:**
  - Combinational single restoring step.
  - Inputs: partial remainder, next bit, divisor. Outputs: new remainder, quotient bit.
  - Instantiated once in the CALC datapath.

## Test plan
- DIVU 100/7: stall high 34 cycles, then LO=14, HI=2; `EX_requireStall` low in cycle 34.
- DIV -7/2 (0xFFFFFFF9 / 2): LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero, 0x12345678/0:
  - LO=0xFFFFFFFF, HI=0x12345678.
  - Stall lasts 2 cycles with `DIV_EARLY_ZERO_EN` defined and 34 without.
- Cancel in cycle 10 of a divide (HI=LO=0xAAAA beforehand): stall drops in cycle 11, HI/LO stay 0xAAAA.
- Divide completes with `hold`=1 for 3 cycles and `start` still high: stays in DONE, no restart, stall stays 0.
- MTHI 0x55 during CALC: `hi`=0x55 next cycle, then overwritten by the remainder at FIX.
- MTLO asserted in the FIX cycle: the divide quotient wins.
